// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state encoding, frame length and parity helper.
// Used by ps2_host_tx and kb_interface.
package ps2_pkg;

    // start + 8 data + parity + stop
    localparam int PS2_FRAME_BITS = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_DATA,
        ST_ACK,
        ST_WAIT_REL,
        ST_DONE,
        ST_ERR
    } ps2_state_e;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for the raw PS/2 clock and data pins plus a
// falling-edge strobe on the synchronized clock.
module ps2_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk_in,
    input  logic ps2_data_in,
    output logic clk_s,
    output logic data_s,
    output logic fall
);

    logic [1:0] clk_ff;
    logic [1:0] data_ff;
    logic       clk_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, which the sync chain relies on.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_ff  <= 2'b11;
            data_ff <= 2'b11;
            clk_q   <= 1'b1;
        end else begin
            clk_ff  <= {clk_ff[0], ps2_clk_in};
            data_ff <= {data_ff[0], ps2_data_in};
            clk_q   <= clk_ff[1];
        end
    end

    assign clk_s  = clk_ff[1];
    assign data_s = data_ff[1];
    assign fall   = clk_q & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, clock out one byte, check ack.
// Define PS2_HOST_TX_TIMEOUT_EN to enable the start and transfer watchdogs.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES    = 10_000,
    parameter int START_TIMEOUT_CYC = 1_500_000,
    parameter int XFER_TIMEOUT_CYC  = 200_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int MAX_SW    = (START_TIMEOUT_CYC > XFER_TIMEOUT_CYC) ? START_TIMEOUT_CYC
                                                                      : XFER_TIMEOUT_CYC;
    localparam int TIMER_MAX = (INHIBIT_CYCLES > MAX_SW) ? INHIBIT_CYCLES : MAX_SW;
    localparam int TIMER_W   = $clog2(TIMER_MAX) + 1;

    ps2_state_e         state, next_state;
    logic [TIMER_W-1:0] timer;
    logic [9:0]         shreg;
    logic [3:0]         bitcnt;
    logic               clk_s, data_s, fall;
    logic               accept, shift_bit, timeout, timer_run, keep_timer;

    ps2_sync_edge u_sync (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .clk_s       (clk_s),
        .data_s      (data_s),
        .fall        (fall)
    );

    assign accept = (state == ST_IDLE) && tx_valid && tx_ready;

    // The transfer watchdog spans DATA, ACK and WAIT_REL, so the timer keeps
    // running across moves between those three states.
    assign keep_timer = (state inside {ST_DATA, ST_ACK, ST_WAIT_REL}) &&
                        (next_state inside {ST_DATA, ST_ACK, ST_WAIT_REL});

`ifdef PS2_HOST_TX_TIMEOUT_EN
    assign timer_run = (state != ST_IDLE);

    always_comb begin
        timeout = 1'b0;
        case (state)
            ST_RTS:                       timeout = (timer == TIMER_W'(START_TIMEOUT_CYC - 1));
            ST_DATA, ST_ACK, ST_WAIT_REL: timeout = (timer == TIMER_W'(XFER_TIMEOUT_CYC - 1));
            default:                      timeout = 1'b0;
        endcase
    end
`else
    assign timer_run = (state == ST_INHIBIT);
    assign timeout   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        shift_bit  = 1'b0;
        case (state)
            ST_IDLE:    if (accept) next_state = ST_INHIBIT;
            ST_INHIBIT: if (timer == TIMER_W'(INHIBIT_CYCLES - 1)) next_state = ST_RTS;
            ST_RTS: begin
                if (timeout) next_state = ST_ERR;
                else if (fall) begin
                    next_state = ST_DATA;
                    shift_bit  = 1'b1;
                end
            end
            ST_DATA: begin
                if (timeout) next_state = ST_ERR;
                else if (fall) begin
                    shift_bit = 1'b1;
                    if (bitcnt == 4'(PS2_FRAME_BITS - 2)) next_state = ST_ACK;
                end
            end
            ST_ACK: begin
                if (timeout)   next_state = ST_ERR;
                else if (fall) next_state = data_s ? ST_ERR : ST_WAIT_REL;
            end
            ST_WAIT_REL: begin
                if (timeout)              next_state = ST_ERR;
                else if (clk_s && data_s) next_state = ST_DONE;
            end
            ST_DONE:  next_state = ST_IDLE;
            ST_ERR:   next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)                                      timer <= '0;
        else if ((next_state != state) && !keep_timer) timer <= '0;
        else if (timer_run)                             timer <= timer + TIMER_W'(1);
    end

    // Ones shifted in from the top leave the line released once the frame is out.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg  <= '1;
            bitcnt <= '0;
        end else if (accept) begin
            shreg  <= {1'b1, odd_parity(tx_data), tx_data};
            bitcnt <= '0;
        end else if (shift_bit) begin
            shreg  <= {1'b1, shreg[9:1]};
            bitcnt <= bitcnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_ready    <= 1'b0;
            busy        <= 1'b0;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
        end else begin
            tx_ready   <= (next_state == ST_IDLE);
            busy       <= (next_state != ST_IDLE);
            tx_done    <= (next_state == ST_DONE);
            tx_err     <= (next_state == ST_ERR);
            ps2_clk_oe <= (next_state == ST_INHIBIT);
            if (next_state == ST_RTS)
                ps2_data_oe <= 1'b1;
            else if (shift_bit)
                ps2_data_oe <= ~shreg[0];
            else if (!(next_state inside {ST_DATA, ST_ACK, ST_WAIT_REL}))
                ps2_data_oe <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: scaled-down device model that clocks frames in and acks/NACKs,
// with a scoreboard of expected frames and outcome pulses.
module tb_ps2_host_tx;

    localparam int INH   = 200;
    localparam int START = 2000;
    localparam int XFER  = 1500;
    localparam int HALF  = 40;

    typedef struct {
        logic [10:0] bits;
        logic [7:0]  data;
        logic        ok;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, busy, tx_done, tx_err;
    logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low, dev_data_low;
    logic       bfm_nack, bfm_silent;
    int         bfm_edges;

    int          errors = 0;
    int          checks = 0;
    int          done_cnt = 0, err_cnt = 0;
    int          done_base, err_base;
    exp_t        exp_q[$];
    logic [10:0] rx_q[$];

    always #5 clk = ~clk;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES    (INH),
        .START_TIMEOUT_CYC (START),
        .XFER_TIMEOUT_CYC  (XFER)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .tx_done     (tx_done),
        .tx_err      (tx_err),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always @(negedge clk) begin
        if (tx_done === 1'b1) done_cnt++;
        if (tx_err === 1'b1)  err_cnt++;
    end

    // Device: waits for request-to-send, reads the start bit, then clocks ten
    // bits in on rising edges and acks (or NACKs) on the eleventh clock.
    initial begin : device_bfm
        logic [10:0] rx;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        bfm_edges    = 0;
        forever begin
            wait (ps2_clk_in === 1'b0);
            wait (ps2_clk_in === 1'b1);
            @(negedge clk);
            if (ps2_data_in !== 1'b0) continue;
            if (bfm_silent) begin
                wait (ps2_data_in === 1'b1);
                continue;
            end
            bfm_edges = 0;
            repeat (HALF) @(negedge clk);
            rx[0] = ps2_data_in;
            for (int i = 1; i < 11; i++) begin
                dev_clk_low = 1'b1;
                bfm_edges++;
                repeat (HALF) @(negedge clk);
                dev_clk_low = 1'b0;
                @(negedge clk);
                rx[i] = ps2_data_in;
                repeat (HALF - 1) @(negedge clk);
            end
            if (!bfm_nack) dev_data_low = 1'b1;
            repeat (HALF / 2) @(negedge clk);
            dev_clk_low = 1'b1;
            bfm_edges++;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (HALF / 2) @(negedge clk);
            dev_data_low = 1'b0;
            rx_q.push_back(rx);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic ok);
        exp_t e;
        logic par;
        par    = ($countones(d) % 2) == 0;
        e.bits = {1'b1, par, d, 1'b0};
        e.data = d;
        e.ok   = ok;
        exp_q.push_back(e);
    endtask

    // Drive a request until busy rises; optionally leave tx_valid asserted.
    task automatic send(input logic [7:0] d, input bit hold);
        int n;
        n         = 0;
        done_base = done_cnt;
        err_base  = err_cnt;
        tx_data   = d;
        tx_valid  = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (busy !== 1'b1 && n < 100);
        if (!hold) tx_valid = 1'b0;
        check($sformatf("accept_%02h", d), busy, 1);
    endtask

    task automatic finish_xfer(input bit expect_idle);
        exp_t        e;
        logic [10:0] got;
        int          n;
        n = 0;
        while (rx_q.size() == 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        e   = exp_q.pop_front();
        got = (rx_q.size() != 0) ? rx_q.pop_front() : 11'bx;
        check($sformatf("frame_%02h", e.data), got, e.bits);
        repeat (20) @(negedge clk);
        check($sformatf("done_pulses_%02h", e.data), done_cnt - done_base, e.ok ? 1 : 0);
        check($sformatf("err_pulses_%02h", e.data), err_cnt - err_base, e.ok ? 0 : 1);
        if (expect_idle) begin
            check("busy_after", busy, 0);
            check("ready_after", tx_ready, 1);
        end
    endtask

    initial begin : stimulus
        int n;
        reset      = 1'b1;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        bfm_nack   = 1'b0;
        bfm_silent = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_ready", tx_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_err", tx_err, 0);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", tx_ready, 1);

        // 1: 0xED, inhibit length, start bit, ack
        send(8'hED, 0);
        expect_frame(8'hED, 1);
        n = 0;
        while (ps2_clk_oe === 1'b1 && n < 4 * INH) begin
            n++;
            @(negedge clk);
        end
        check("inhibit_cycles", n, INH);
        check("rts_data_oe", ps2_data_oe, 1);
        finish_xfer(1);

        // 2: parity 0 and parity 1 cases
        send(8'hF4, 0);
        expect_frame(8'hF4, 1);
        finish_xfer(1);
        send(8'h00, 0);
        expect_frame(8'h00, 1);
        finish_xfer(1);

        // 3: NACK
        bfm_nack = 1'b1;
        send(8'hFF, 0);
        expect_frame(8'hFF, 0);
        n = 0;
        while (tx_err !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("nack_err", tx_err, 1);
        check("nack_clk_oe", ps2_clk_oe, 0);
        check("nack_data_oe", ps2_data_oe, 0);
        @(negedge clk);
        check("nack_err_width", tx_err, 0);
        check("nack_ready", tx_ready, 1);
        finish_xfer(1);
        bfm_nack = 1'b0;

        // 4: silent device after request-to-send
        bfm_silent = 1'b1;
        send(8'h55, 0);
        n = 0;
        while (ps2_clk_oe === 1'b1 && n < 4 * INH) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (tx_err !== 1'b1 && n < 2 * START) begin
            @(negedge clk);
            n++;
        end
`ifdef PS2_HOST_TX_TIMEOUT_EN
        check("start_timeout_cycles", n, START);
        check("start_timeout_err", err_cnt - err_base, 1);
        @(negedge clk);
        check("start_timeout_ready", tx_ready, 1);
        check("start_timeout_data_oe", ps2_data_oe, 0);
`else
        check("no_timeout_busy", busy, 1);
        check("no_timeout_err", err_cnt - err_base, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("no_timeout_ready", tx_ready, 1);
`endif
        bfm_silent = 1'b0;
        repeat (10) @(negedge clk);

        // 5: reset after edge 5, then a clean byte
        send(8'hED, 0);
        n = 0;
        while (bfm_edges != 5 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("edge5_reached", bfm_edges, 5);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_clk_oe", ps2_clk_oe, 0);
        check("midrst_data_oe", ps2_data_oe, 0);
        check("midrst_ready", tx_ready, 0);
        check("midrst_busy", busy, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n = 0;
        while (rx_q.size() == 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (rx_q.size() != 0) void'(rx_q.pop_front());
        repeat (20) @(negedge clk);
        check("midrst_no_done", done_cnt - done_base, 0);
        check("midrst_no_err", err_cnt - err_base, 0);
        send(8'hA5, 0);
        expect_frame(8'hA5, 1);
        finish_xfer(1);

        // 6: request held during a transfer
        send(8'hED, 1);
        tx_data = 8'h12;
        expect_frame(8'hED, 1);
        n = 0;
        while (tx_done !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("hold_done", tx_done, 1);
        @(negedge clk);
        check("hold_idle_ready", tx_ready, 1);
        check("hold_idle_busy", busy, 0);
        @(negedge clk);
        check("hold_accept_12", busy, 1);
        tx_valid = 1'b0;
        finish_xfer(0);
        done_base = done_cnt;
        err_base  = err_cnt;
        expect_frame(8'h12, 1);
        finish_xfer(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
